// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts rising edges of a spike train over back-to-back
// windows of programmable length, delivers each window's count through a
// valid/ready handshake, and tracks the interval between the last two spikes.
module spike_rate_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       spike,
    input  logic [7:0] win_len,
    input  logic       ready,
    output logic [7:0] rate,
    output logic [7:0] isi,
    output logic       valid,
    output logic       overrun
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       enter;       // IDLE -> COUNT this cycle
    logic       counting;    // COUNT and staying in COUNT
    logic       leaving;     // COUNT -> IDLE this cycle
    logic       win_end;
    logic       prev_spike;
    logic       spike_edge;
    logic [7:0] win_q;       // window length latched at window start
    logic [7:0] cyc_cnt;     // cycle index within the current window
    logic [7:0] spk_cnt;     // spikes seen so far in the current window
    logic [7:0] cnt_now;     // spike count including this cycle's edge
    logic [7:0] itv_cnt;     // cycles since the most recent spike
    logic       first_seen;  // a spike has occurred since entering COUNT

    // Previous-level register runs every cycle so a held-high level counts once.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its peers, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_spike <= 1'b0;
        else        prev_spike <= spike;
    end

    assign spike_edge = spike & ~prev_spike;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and transition qualifiers.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        enter    = 1'b0;
        counting = 1'b0;
        leaving  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ena) begin
                    state_d = ST_COUNT;
                    enter   = 1'b1;
                end
            end
            ST_COUNT: begin
                if (ena) begin
                    counting = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    leaving = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign win_end = counting && (cyc_cnt == win_q);
    assign cnt_now = (spike_edge && (spk_cnt != 8'hFF)) ? spk_cnt + 8'd1 : spk_cnt;

    // Window bookkeeping: latch length at each window start, count cycles and edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= 8'd0;
            cyc_cnt <= 8'd0;
            spk_cnt <= 8'd0;
        end else if (enter || win_end) begin
            win_q   <= win_len;
            cyc_cnt <= 8'd0;
            spk_cnt <= 8'd0;
        end else if (counting) begin
            cyc_cnt <= cyc_cnt + 8'd1;
            spk_cnt <= cnt_now;
        end else begin
            // Idle or aborting: any partial window is thrown away.
            cyc_cnt <= 8'd0;
            spk_cnt <= 8'd0;
        end
    end

    // Inter-spike interval: free-running saturating counter restarted by each spike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            itv_cnt    <= 8'd0;
            first_seen <= 1'b0;
            isi        <= 8'd0;
        end else if (enter) begin
            itv_cnt    <= 8'd0;
            first_seen <= 1'b0;
        end else if (counting) begin
            if (spike_edge) begin
                itv_cnt    <= 8'd1;
                first_seen <= 1'b1;
                if (first_seen) isi <= itv_cnt;
            end else if (itv_cnt != 8'hFF) begin
                itv_cnt <= itv_cnt + 8'd1;
            end
        end else if (leaving) begin
            first_seen <= 1'b0;
        end
    end

    // Result delivery: load on window end unless a result is still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate    <= 8'd0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (win_end && (!valid || ready)) begin
            rate  <= cnt_now;
            valid <= 1'b1;
        end else if (win_end) begin
            overrun <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed scenarios plus
// randomized windows checked against a timestamp/edge-count reference model.
module tb_spike_rate_decoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       spike;
    logic [7:0] win_len;
    logic       ready;
    logic [7:0] rate;
    logic [7:0] isi;
    logic       valid;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    // Reference model state (cycle timestamps and edge counts).
    logic last_lvl  = 1'b0;
    bit   in_count  = 1'b0;
    bit   have_prev = 1'b0;
    int   t         = 0;
    int   t_prev    = 0;
    int   exp_isi   = 0;
    int   win_edges = 0;

    spike_rate_decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .spike   (spike),
        .win_len (win_len),
        .ready   (ready),
        .rate    (rate),
        .isi     (isi),
        .valid   (valid),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of spike level, then update the model from the stimulus.
    task automatic tick(input logic sp);
        spike = sp;
        @(posedge clk);
        #1;
        if (in_count) begin
            if (sp && !last_lvl) begin
                win_edges = (win_edges >= 255) ? 255 : win_edges + 1;
                if (have_prev) exp_isi = ((t - t_prev) > 255) ? 255 : (t - t_prev);
                have_prev = 1'b1;
                t_prev    = t;
            end
            t++;
        end
        last_lvl = sp;
    endtask

    task automatic start_count(input logic [7:0] wl);
        ena       = 1'b1;
        win_len   = wl;
        in_count  = 1'b0;
        tick(1'b0);
        in_count  = 1'b1;
        have_prev = 1'b0;
        win_edges = 0;
        t         = 0;
    endtask

    task automatic stop_count();
        ena       = 1'b0;
        ready     = 1'b1;
        in_count  = 1'b0;
        tick(1'b0);
        have_prev = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ena     = 1'b0;
        spike   = 1'b0;
        win_len = 8'd0;
        ready   = 1'b0;
        #3;
        total++;
        if (rate !== 8'd0 || isi !== 8'd0 || valid !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: rate=%0d isi=%0d valid=%b overrun=%b expected all zero",
                     rate, isi, valid, overrun);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_valid: got %b expected 0", valid);
        end
    endtask

    task automatic test_basic_window();
        ready = 1'b1;
        start_count(8'd9);
        for (int i = 0; i < 10; i++) begin
            tick((i == 0) || (i == 3) || (i == 9));
            if (i < 9) begin
                total++;
                if (valid !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_early_valid: cycle %0d valid=%b expected 0", i, valid);
                end
            end
        end
        total++;
        if (valid !== 1'b1 || rate !== 8'd3) begin
            bad++;
            $display("FAIL basic_result: valid=%b rate=%0d expected valid=1 rate=3", valid, rate);
        end
        total++;
        if (isi !== 8'd6) begin
            bad++;
            $display("FAIL basic_isi: got %0d expected 6", isi);
        end
        tick(1'b0);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_valid_pulse: got %b expected 0", valid);
        end
    endtask

    task automatic test_held_spike();
        stop_count();
        start_count(8'd0);
        for (int i = 0; i < 8; i++) begin
            win_edges = 0;
            tick(i < 5);
            total++;
            if (valid !== 1'b1 || rate !== 8'(win_edges) || rate !== ((i == 0) ? 8'd1 : 8'd0)) begin
                bad++;
                $display("FAIL held_rate: cycle %0d valid=%b rate=%0d expected valid=1 rate=%0d",
                         i, valid, rate, win_edges);
            end
        end
        total++;
        if (isi !== 8'd6) begin
            bad++;
            $display("FAIL held_isi_hold: got %0d expected 6", isi);
        end
    endtask

    task automatic test_overrun();
        stop_count();
        ready = 1'b0;
        start_count(8'd7);
        for (int w = 0; w < 2; w++) begin
            win_edges = 0;
            for (int i = 0; i < 8; i++) tick((i % 2 == 0) && (w == 1 || i < 4));
            total++;
            if (win_edges != 2 * (w + 1)) begin
                bad++;
                $display("FAIL overrun_stimulus: window %0d edges=%0d expected %0d",
                         w, win_edges, 2 * (w + 1));
            end
            total++;
            if (rate !== 8'd2 || valid !== 1'b1 || overrun !== (w == 1)) begin
                bad++;
                $display("FAIL overrun_window%0d: rate=%0d valid=%b overrun=%b expected 2/1/%0d",
                         w, rate, valid, overrun, w);
            end
        end
        ready = 1'b1;
        tick(1'b0);
        total++;
        if (valid !== 1'b0 || rate !== 8'd2 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_handshake: valid=%b rate=%0d overrun=%b expected 0/2/1",
                     valid, rate, overrun);
        end
        total++;
        if (isi !== 8'(exp_isi)) begin
            bad++;
            $display("FAIL overrun_isi: got %0d expected %0d", isi, exp_isi);
        end
    endtask

    task automatic test_isi();
        stop_count();
        start_count(8'd255);
        tick(1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0);
        tick(1'b1);
        total++;
        if (isi !== 8'd7 || exp_isi != 7) begin
            bad++;
            $display("FAIL isi_7: got %0d expected 7 (model %0d)", isi, exp_isi);
        end
        for (int i = 0; i < 299; i++) tick(1'b0);
        tick(1'b1);
        total++;
        if (isi !== 8'd255 || exp_isi != 255) begin
            bad++;
            $display("FAIL isi_sat: got %0d expected 255 (model %0d)", isi, exp_isi);
        end
    endtask

    task automatic test_rate_saturation();
        stop_count();
        start_count(8'd255);
        for (int i = 0; i < 256; i++) tick(i % 2 == 0);
        total++;
        if (rate !== 8'd128 || valid !== 1'b1 || win_edges != 128) begin
            bad++;
            $display("FAIL rate_128: rate=%0d valid=%b expected 128/1 (model %0d)",
                     rate, valid, win_edges);
        end
        win_edges = 0;
        for (int i = 0; i < 256; i++) begin
            tick(i % 2 == 0);
            if (i == 3) begin
                force dut.spk_cnt = 8'd253;
                #1;
                release dut.spk_cnt;
                win_edges = 253;
            end
        end
        total++;
        if (rate !== 8'(win_edges) || rate !== 8'd255) begin
            bad++;
            $display("FAIL rate_sat: rate=%0d expected %0d", rate, win_edges);
        end
    endtask

    task automatic test_abort();
        logic [7:0] held_rate;
        stop_count();
        held_rate = rate;
        start_count(8'd9);
        for (int i = 0; i < 5; i++) tick((i == 1) || (i == 3));
        stop_count();
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            total++;
            if (valid !== 1'b0 || rate !== held_rate) begin
                bad++;
                $display("FAIL abort_no_result: cycle %0d valid=%b rate=%0d expected 0/%0d",
                         i, valid, rate, held_rate);
            end
        end
        start_count(8'd9);
        for (int i = 0; i < 10; i++) tick(i == 2);
        total++;
        if (valid !== 1'b1 || rate !== 8'd1) begin
            bad++;
            $display("FAIL abort_fresh_window: valid=%b rate=%0d expected 1/1", valid, rate);
        end
        for (int i = 0; i < 4; i++) tick(i == 1);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (rate !== 8'd0 || isi !== 8'd0 || valid !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL abort_async_reset: rate=%0d isi=%0d valid=%b overrun=%b expected zeros",
                     rate, isi, valid, overrun);
        end
        ena = 1'b0;
        in_count = 1'b0;
        have_prev = 1'b0;
        exp_isi = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_random_windows();
        int wl;
        int next_wl;
        ready = 1'b1;
        wl = $urandom_range(0, 12);
        start_count(8'(wl));
        for (int w = 0; w < 10; w++) begin
            next_wl = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
            win_edges = 0;
            for (int i = 0; i <= wl; i++) begin
                win_len = (i == wl) ? 8'(next_wl) : 8'($urandom);
                tick(1'($urandom_range(0, 1)));
                total++;
                if (isi !== 8'(exp_isi)) begin
                    bad++;
                    $display("FAIL rand_isi: win %0d cycle %0d got %0d expected %0d",
                             w, i, isi, exp_isi);
                end
                if (i < wl) begin
                    total++;
                    if (valid !== 1'b0) begin
                        bad++;
                        $display("FAIL rand_valid_mid: win %0d cycle %0d got %b expected 0",
                                 w, i, valid);
                    end
                end
            end
            total++;
            if (valid !== 1'b1 || rate !== 8'(win_edges)) begin
                bad++;
                $display("FAIL rand_rate: win %0d len %0d valid=%b rate=%0d expected 1/%0d",
                         w, wl + 1, valid, rate, win_edges);
            end
            wl = next_wl;
        end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_held_spike();
        test_overrun();
        test_isi();
        test_rate_saturation();
        test_abort();
        test_random_windows();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
